// File: rtl/grom_bus_pkg.sv
// Shared definitions for the grom8 two-master bus arbiter.
// Holds the default widths, the owner encodings and the lock counter width.
package grom_bus_pkg;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_LOCK = 15;

    // Wide enough for the largest allowed MAX_LOCK (255)
    localparam int LOCK_CNT_W = 8;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    function automatic owner_t owner_of(input logic master);
        return master ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/grom_arb_pick.sv
// Combinational winner selection for the two-master bus arbiter.
// Applies the lock hold, then round-robin, and computes the next lock count.
module grom_arb_pick
    import grom_bus_pkg::*;
#(
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic [1:0]            elig,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic                  last,
    input  logic [LOCK_CNT_W-1:0] lock_cnt,
    output logic                  grant,
    output logic                  winner,
    output logic [LOCK_CNT_W-1:0] lock_cnt_next
);

    localparam logic [LOCK_CNT_W-1:0] LIMIT = LOCK_CNT_W'(MAX_LOCK);

    logic hold;

    always_comb begin
        hold          = lock[last] & req[last] & (lock_cnt < LIMIT);
        grant         = 1'b0;
        winner        = last;
        lock_cnt_next = lock_cnt;

        // During a hold the other master waits even while the holder sits out its gap cycle
        if (hold) begin
            grant  = elig[last];
            winner = last;
        end else if (elig[0] && elig[1]) begin
            grant  = 1'b1;
            winner = ~last;
        end else if (elig[0]) begin
            grant  = 1'b1;
            winner = 1'b0;
        end else if (elig[1]) begin
            grant  = 1'b1;
            winner = 1'b1;
        end

        if (grant) begin
            if (!lock[winner]) begin
                lock_cnt_next = '0;
            end else if (winner != last) begin
                lock_cnt_next = LOCK_CNT_W'(1);
            end else if (lock_cnt < LIMIT) begin
                lock_cnt_next = lock_cnt + 1'b1;
            end else begin
                lock_cnt_next = lock_cnt;
            end
        end else if (!lock[last]) begin
            lock_cnt_next = '0;
        end
    end

endmodule

// File: rtl/grom_bus_arbiter.sv
// Two-master arbiter for the grom8 12-bit memory/IO bus.
// Registers one granted access per cycle onto the bus and flags read data one cycle later.
module grom_bus_arbiter
    import grom_bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    input  logic              m0_ioreq,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    input  logic              m1_ioreq,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              we,
    output logic              ioreq,
    input  logic [DATA_W-1:0] data_in,
    output logic [1:0]        owner
);

    owner_t                owner_q, owner_d;
    logic                  last_q, last_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0]     addr_d;
    logic [DATA_W-1:0]     data_d;
    logic                  we_d, ioreq_d;
    logic [1:0]            rvalid_p2, rvalid_d;

    logic [1:0]            elig;
    logic                  grant, winner;

    assign elig = {m1_req & ~m1_gnt, m0_req & ~m0_gnt};

    grom_arb_pick #(
        .MAX_LOCK (MAX_LOCK)
    ) u_pick (
        .elig          (elig),
        .req           ({m1_req, m0_req}),
        .lock          ({m1_lock, m0_lock}),
        .last          (last_q),
        .lock_cnt      (lock_cnt_q),
        .grant         (grant),
        .winner        (winner),
        .lock_cnt_next (lock_cnt_d)
    );

    // Issue stage: the selected master's fields become the bus cycle
    always_comb begin
        owner_d  = OWN_IDLE;
        last_d   = last_q;
        addr_d   = addr;
        data_d   = data_out;
        we_d     = 1'b0;
        ioreq_d  = 1'b0;
        rvalid_d = {m1_gnt & ~we, m0_gnt & ~we};

        if (grant) begin
            owner_d = owner_of(winner);
            last_d  = winner;
            if (winner) begin
                addr_d  = m1_addr;
                data_d  = m1_wdata;
                we_d    = m1_we;
                ioreq_d = m1_ioreq;
            end else begin
                addr_d  = m0_addr;
                data_d  = m0_wdata;
                we_d    = m0_we;
                ioreq_d = m0_ioreq;
            end
        end
    end

    // Bus stage and read-return stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            addr       <= '0;
            data_out   <= '0;
            we         <= 1'b0;
            ioreq      <= 1'b0;
            rvalid_p2  <= 2'b00;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            addr       <= addr_d;
            data_out   <= data_d;
            we         <= we_d;
            ioreq      <= ioreq_d;
            rvalid_p2  <= rvalid_d;
        end
    end

    always_comb begin
        owner     = owner_q;
        m0_gnt    = (owner_q == OWN_M0);
        m1_gnt    = (owner_q == OWN_M1);
        m0_rvalid = rvalid_p2[0];
        m1_rvalid = rvalid_p2[1];
        m0_rdata  = data_in;
        m1_rdata  = data_in;
    end

endmodule

// File: tb/tb_grom_bus_arbiter.sv
// Directed bench for grom_bus_arbiter with a one-cycle-latency memory model.
// Expected values below are worked out by hand from the bus timing.
module tb_grom_bus_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              m0_req, m0_lock, m0_we, m0_ioreq;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt, m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req, m1_lock, m1_we, m1_ioreq;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              we, ioreq;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        owner;

    int n_checks = 0;
    int n_errors = 0;

    grom_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_ioreq  (m0_ioreq),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_ioreq  (m1_ioreq),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .addr      (addr),
        .data_out  (data_out),
        .we        (we),
        .ioreq     (ioreq),
        .data_in   (data_in),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_at(input logic [ADDR_W-1:0] a);
        return (a == 12'h123) ? 8'hA5 : (a[7:0] ^ 8'h3C);
    endfunction

    // Memory answers one cycle after the address is on the bus
    always @(posedge clk) data_in <= mem_at(addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " addr"},      32'(addr), 32'h0);
        check({tag, " data_out"},  32'(data_out), 32'h0);
        check({tag, " we"},        32'(we), 32'h0);
        check({tag, " ioreq"},     32'(ioreq), 32'h0);
        check({tag, " m0_gnt"},    32'(m0_gnt), 32'h0);
        check({tag, " m1_gnt"},    32'(m1_gnt), 32'h0);
        check({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'h0);
        check({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'h0);
        check({tag, " owner"},     32'(owner), 32'h0);
    endtask

    int rr_seq[6]   = '{1, 2, 1, 2, 1, 2};
    int lock_seq[7] = '{2, 0, 2, 0, 2, 1, 2};

    initial begin
        reset = 1'b0;
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_ioreq = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_ioreq = 0; m1_addr = '0; m1_wdata = '0;

        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b1;

        // Round-robin: m0 wins the first tie, then strict alternation
        m0_addr = 12'h040; m1_addr = 12'h080;
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr owner %0d", i), 32'(owner), 32'(rr_seq[i]));
            check($sformatf("rr m0_gnt %0d", i), 32'(m0_gnt), 32'(rr_seq[i] == 1));
        end
        m0_req = 0; m1_req = 0;
        tick();
        check("rr idle owner", 32'(owner), 32'h0);

        // m0 memory read of 0x123
        m0_req = 1; m0_addr = 12'h123; m0_we = 0; m0_ioreq = 0;
        tick();
        check("rd m0_gnt", 32'(m0_gnt), 32'h1);
        check("rd addr", 32'(addr), 32'h123);
        check("rd we", 32'(we), 32'h0);
        check("rd owner", 32'(owner), 32'h1);
        m0_req = 0;
        tick();
        check("rd m0_rvalid", 32'(m0_rvalid), 32'h1);
        check("rd m0_rdata", 32'(m0_rdata), 32'hA5);
        check("rd m0_gnt after", 32'(m0_gnt), 32'h0);
        check("rd m1_rvalid", 32'(m1_rvalid), 32'h0);

        // m0 IO write of 0x5C to 0x010
        m0_req = 1; m0_addr = 12'h010; m0_wdata = 8'h5C; m0_we = 1; m0_ioreq = 1;
        tick();
        check("wr m0_gnt", 32'(m0_gnt), 32'h1);
        check("wr we", 32'(we), 32'h1);
        check("wr ioreq", 32'(ioreq), 32'h1);
        check("wr data_out", 32'(data_out), 32'h5C);
        check("wr addr", 32'(addr), 32'h010);
        m0_req = 0; m0_we = 0; m0_ioreq = 0;
        tick();
        check("wr no rvalid", 32'(m0_rvalid), 32'h0);
        check("wr idle we", 32'(we), 32'h0);
        check("wr idle ioreq", 32'(ioreq), 32'h0);
        check("wr addr hold", 32'(addr), 32'h010);
        tick();
        check("wr no rvalid 2", 32'(m0_rvalid), 32'h0);

        // m1 locks with MAX_LOCK=3 while m0 keeps requesting
        m1_req = 1; m1_lock = 1; m1_addr = 12'h200;
        m0_req = 1; m0_addr = 12'h300;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("lock owner %0d", i), 32'(owner), 32'(lock_seq[i]));
        end
        m0_req = 0; m1_req = 0; m1_lock = 0;
        tick();
        check("lock release idle", 32'(owner), 32'h0);
        tick();

        // Reset asserted during m1's grant cycle
        m1_req = 1; m1_addr = 12'h456; m1_we = 0;
        tick();
        check("rst m1_gnt", 32'(m1_gnt), 32'h1);
        check("rst addr pre", 32'(addr), 32'h456);
        reset = 1'b0;
        #1;
        check_reset_outputs("async rst");
        m1_req = 0;
        tick();
        check_reset_outputs("held rst");
        reset = 1'b1;
        tick();
        check("post rst m1_rvalid", 32'(m1_rvalid), 32'h0);
        check("post rst owner", 32'(owner), 32'h0);
        tick();
        check("post rst m1_rvalid 2", 32'(m1_rvalid), 32'h0);

        // Access to 0x7FF then ten idle cycles
        m0_req = 1; m0_addr = 12'h7FF; m0_we = 1; m0_ioreq = 1; m0_wdata = 8'h11;
        tick();
        check("7ff m0_gnt", 32'(m0_gnt), 32'h1);
        m0_req = 0; m0_we = 0; m0_ioreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle owner %0d", i), 32'(owner), 32'h0);
        end
        check("idle we", 32'(we), 32'h0);
        check("idle ioreq", 32'(ioreq), 32'h0);
        check("idle addr", 32'(addr), 32'h7FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
